// File: rtl/delta_madd_param_if.sv
// Bus bundle for delta_madd_param: command/load inputs and scan status outputs.
interface delta_madd_param_if #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 4,
    parameter int ACC_W  = 12
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [1:0]        op;
    logic              load;
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] data;
    logic              start;
    logic              busy;
    logic              done;
    logic              found;
    logic [ACC_W-1:0]  result;
    logic              err;
    logic              ovf;

    modport master (
        output op, load, index, data, start,
        input  busy, done, found, result, err, ovf
    );

    modport slave (
        input  op, load, index, data, start,
        output busy, done, found, result, err, ovf
    );
endinterface

// File: rtl/delta_madd_param.sv
// Difference-array memory with MIN/MAX first-hit scans and a weighted MADD scan.
// Define DELTA_MADD_SAT_EN to saturate count/total instead of wrapping.
module delta_madd_param #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 4,
    parameter int MEM_W  = 10,
    parameter int ACC_W  = 12
) (
    input logic               clk,
    input logic               rst,
    delta_madd_param_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] OP_MIN   = 2'b00;
    localparam logic [1:0] OP_MAX   = 2'b01;
    localparam logic [1:0] OP_MADD  = 2'b10;

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e                   r_state, w_state_nxt;
    logic [1:0]               r_op;
    logic [IDX_W-1:0]         r_idx;
    logic signed [MEM_W-1:0]  r_mem [DEPTH];
    logic signed [ACC_W-1:0]  r_delta, r_count, r_total;
    logic [ACC_W-1:0]         r_result;
    logic                     r_found, r_err, r_ovf;

    logic                     w_load_ok, w_start_ok, w_err_set;
    logic [IDX_W-1:0]         w_index_m1;
    logic signed [MEM_W-1:0]  w_mem_cur;
    logic                     w_hit, w_scan_end;
    logic signed [ACC_W-1:0]  w_delta_nxt, w_count_nxt, w_total_nxt;
    logic [ACC_W:0]           w_cnt_add, w_tot_add;

    // Returns {overflow, sum}; the sum is clamped when saturation is enabled.
    function automatic logic [ACC_W:0] acc_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        logic           ov;
        s  = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        ov = s[ACC_W] ^ s[ACC_W-1];
`ifdef DELTA_MADD_SAT_EN
        if (ov) begin
            return {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
        end
`endif
        return {ov, s[ACC_W-1:0]};
    endfunction

    assign w_load_ok  = bus.load && (r_state == StIdle);
    assign w_start_ok = bus.start && !bus.load && (r_state == StIdle);
    assign w_err_set  = ((r_state == StScan) && (bus.load || bus.start)) ||
                        ((r_state == StIdle) && bus.load && bus.start);
    assign w_index_m1 = bus.index - IDX_W'(1);

    assign w_mem_cur   = r_mem[r_idx];
    assign w_hit       = (w_mem_cur != '0);
    assign w_delta_nxt = r_delta + ACC_W'(w_mem_cur);
    assign w_cnt_add   = acc_add(r_count, w_delta_nxt);
    assign w_count_nxt = w_cnt_add[ACC_W-1:0];
    assign w_tot_add   = acc_add(r_total, w_count_nxt);
    assign w_total_nxt = w_tot_add[ACC_W-1:0];

    always_comb begin
        w_scan_end = 1'b1;
        case (r_op)
            OP_MIN:  w_scan_end = w_hit || (r_idx == IDX_W'(DEPTH - 1));
            OP_MAX:  w_scan_end = w_hit || (r_idx == '0);
            OP_MADD: w_scan_end = (r_idx == '0);
            default: w_scan_end = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (w_start_ok) w_state_nxt = StScan;
            StScan:  if (w_scan_end) w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_op     <= 2'b00;
            r_idx    <= '0;
            r_delta  <= '0;
            r_count  <= '0;
            r_total  <= '0;
            r_result <= '0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
            r_ovf    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_err_set) r_err <= 1'b1;

            if (w_load_ok) begin
                case (bus.op)
                    OP_MIN, OP_MAX: r_mem[bus.index] <= MEM_W'(1);
                    OP_MADD: begin
                        r_mem[bus.index] <= r_mem[bus.index] + MEM_W'(bus.data);
                        // Entry 0 has no lower neighbour; the delta simply ends there.
                        if (bus.index != '0) begin
                            r_mem[w_index_m1] <= r_mem[w_index_m1] - MEM_W'(bus.data);
                        end
                    end
                    default: for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
                endcase
            end

            if (w_start_ok) begin
                r_op    <= bus.op;
                r_found <= 1'b0;
                r_ovf   <= 1'b0;
                r_delta <= '0;
                r_count <= '0;
                r_total <= '0;
                r_idx   <= (bus.op == OP_MIN) ? '0 : IDX_W'(DEPTH - 1);
            end

            if (r_state == StScan) begin
                if (r_op == OP_MIN) r_idx <= r_idx + 1'b1;
                else                r_idx <= r_idx - 1'b1;
                if (r_op == OP_MADD) begin
                    r_delta <= w_delta_nxt;
                    r_count <= w_count_nxt;
                    r_total <= w_total_nxt;
                    if (w_cnt_add[ACC_W] || w_tot_add[ACC_W]) r_ovf <= 1'b1;
                end
                if (w_scan_end) begin
                    case (r_op)
                        OP_MIN, OP_MAX: begin
                            r_found  <= w_hit;
                            r_result <= w_hit ? ACC_W'(r_idx) : '0;
                        end
                        OP_MADD: r_result <= w_total_nxt;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.busy   = (r_state == StScan);
    assign bus.done   = (r_state == StDone);
    assign bus.found  = r_found;
    assign bus.result = r_result;
    assign bus.err    = r_err;
    assign bus.ovf    = r_ovf;
endmodule

// File: tb/tb_delta_madd_param.sv
// Directed bench for delta_madd_param with a scoreboard of expected scan results.
module tb_delta_madd_param;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 4;
    localparam int MEM_W  = 10;
    localparam int ACC_W  = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    delta_madd_param_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    delta_madd_param #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .MEM_W (MEM_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [ACC_W-1:0] result;
        logic             found;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    int   m_mem[DEPTH];
    int   checks = 0;
    int   errors = 0;
    int   lat, nbusy, ndone;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bus.op    = 2'b00;
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.index = '0;
        bus.data  = '0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        sb.delete();
    endtask

    task automatic do_load(input logic [1:0] op, input int idx, input int d);
        bus.op    = op;
        bus.index = idx[3:0];
        bus.data  = d[DATA_W-1:0];
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
        if (op == 2'b10) begin
            m_mem[idx] += d;
            if (idx > 0) m_mem[idx-1] -= d;
        end else if (op == 2'b11) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        end else begin
            m_mem[idx] = 1;
        end
    endtask

    // MADD total in closed form: entry i contributes mem[i]*(i+1)(i+2)/2.
    function automatic exp_t predict(input logic [1:0] op);
        exp_t   e;
        longint exact;
        e.result = '0;
        e.found  = 1'b0;
        e.ovf    = 1'b0;
        if (op == 2'b00) begin
            for (int i = DEPTH - 1; i >= 0; i--)
                if (m_mem[i] != 0) begin e.result = ACC_W'(i); e.found = 1'b1; end
        end else if (op == 2'b01) begin
            for (int i = 0; i < DEPTH; i++)
                if (m_mem[i] != 0) begin e.result = ACC_W'(i); e.found = 1'b1; end
        end else begin
            exact = 0;
            for (int i = 0; i < DEPTH; i++) exact += longint'(m_mem[i]) * ((i + 1) * (i + 2) / 2);
            e.ovf = (exact > 2047) || (exact < -2048);
`ifdef DELTA_MADD_SAT_EN
            if (exact > 2047)       e.result = 12'h7FF;
            else if (exact < -2048) e.result = 12'h800;
            else                    e.result = ACC_W'(exact);
`else
            e.result = ACC_W'(exact);
`endif
        end
        return e;
    endfunction

    task automatic run_scan(input logic [1:0] op, input bit poke, output int l, output int nb);
        exp_t e;
        sb.push_back(predict(op));
        bus.op    = op;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        l  = 1;
        nb = 0;
        while (bus.done !== 1'b1 && l < 100) begin
            if (bus.busy === 1'b1) nb++;
            bus.load = poke && (l == 2);
            step();
            bus.load = 1'b0;
            l++;
        end
        chk("done_seen", {31'b0, bus.done}, 1);
        if (bus.done === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_result", {20'b0, bus.result}, {20'b0, e.result});
            chk("sb_found", {31'b0, bus.found}, {31'b0, e.found});
            chk("sb_ovf", {31'b0, bus.ovf}, {31'b0, e.ovf});
        end
        step();
        chk("done_pulse", {31'b0, bus.done}, 0);
        chk("idle_busy", {31'b0, bus.busy}, 0);
    endtask

    initial begin
        do_reset();
        chk("rst_busy", {31'b0, bus.busy}, 0);
        chk("rst_done", {31'b0, bus.done}, 0);
        chk("rst_found", {31'b0, bus.found}, 0);
        chk("rst_result", {20'b0, bus.result}, 0);
        chk("rst_err", {31'b0, bus.err}, 0);
        chk("rst_ovf", {31'b0, bus.ovf}, 0);

        // Single weighted load: 3*(5+1).
        do_load(2'b10, 5, 3);
        run_scan(2'b10, 1'b0, lat, nbusy);
        chk("madd1_busy_cycles", nbusy, 16);
        chk("madd1_latency", lat, 17);
        chk("madd1_result", {20'b0, bus.result}, 18);
        chk("madd1_ovf", {31'b0, bus.ovf}, 0);

        do_reset();
        do_load(2'b10, 0, 7);
        do_load(2'b10, 15, 1);
        run_scan(2'b10, 1'b0, lat, nbusy);
        chk("madd2_result", {20'b0, bus.result}, 23);

        do_reset();
        do_load(2'b00, 9, 0);
        run_scan(2'b00, 1'b0, lat, nbusy);
        chk("min9_latency", lat, 11);
        chk("min9_found", {31'b0, bus.found}, 1);
        chk("min9_result", {20'b0, bus.result}, 9);
        run_scan(2'b01, 1'b0, lat, nbusy);
        chk("max9_result", {20'b0, bus.result}, 9);
        do_load(2'b01, 3, 0);
        run_scan(2'b00, 1'b0, lat, nbusy);
        chk("min3_result", {20'b0, bus.result}, 3);
        run_scan(2'b01, 1'b0, lat, nbusy);
        chk("max_two_result", {20'b0, bus.result}, 9);

        do_reset();
        run_scan(2'b00, 1'b0, lat, nbusy);
        chk("empty_busy_cycles", nbusy, 16);
        chk("empty_found", {31'b0, bus.found}, 0);
        chk("empty_result", {20'b0, bus.result}, 0);

        do_reset();
        for (int k = 0; k < 15; k++) do_load(2'b10, 15, 15);
        run_scan(2'b10, 1'b0, lat, nbusy);
        chk("big_ovf", {31'b0, bus.ovf}, 1);
`ifdef DELTA_MADD_SAT_EN
        chk("big_result_sat", {20'b0, bus.result}, 2047);
`else
        chk("big_result_wrap", {20'b0, bus.result}, 32'hE10);
`endif

        // Load during SCAN must be dropped and flag err.
        do_reset();
        do_load(2'b10, 1, 2);
        bus.index = 4'd7;
        bus.data  = 4'd5;
        run_scan(2'b10, 1'b1, lat, nbusy);
        chk("poke_err", {31'b0, bus.err}, 1);
        chk("poke_result", {20'b0, bus.result}, 4);
        run_scan(2'b10, 1'b0, lat, nbusy);
        chk("poke_mem_kept", {20'b0, bus.result}, 4);

        // Reset mid-scan aborts without a done pulse.
        bus.op    = 2'b10;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        chk("midscan_busy", {31'b0, bus.busy}, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        sb.delete();
        chk("abort_busy", {31'b0, bus.busy}, 0);
        chk("abort_done", {31'b0, bus.done}, 0);
        chk("abort_found", {31'b0, bus.found}, 0);
        chk("abort_result", {20'b0, bus.result}, 0);
        chk("abort_err", {31'b0, bus.err}, 0);
        chk("abort_ovf", {31'b0, bus.ovf}, 0);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.done === 1'b1) ndone++;
            step();
        end
        chk("abort_no_done", ndone, 0);
        run_scan(2'b00, 1'b0, lat, nbusy);
        chk("abort_mem_cleared", {31'b0, bus.found}, 0);

        // Simultaneous load and start: load wins, start dropped, err set.
        do_reset();
        bus.op    = 2'b00;
        bus.index = 4'd4;
        bus.load  = 1'b1;
        bus.start = 1'b1;
        step();
        bus.load  = 1'b0;
        bus.start = 1'b0;
        m_mem[4]  = 1;
        chk("both_busy", {31'b0, bus.busy}, 0);
        chk("both_err", {31'b0, bus.err}, 1);
        step();
        chk("both_no_scan", {31'b0, bus.busy}, 0);
        run_scan(2'b00, 1'b0, lat, nbusy);
        chk("both_load_done", {20'b0, bus.result}, 4);
        chk("both_err_sticky", {31'b0, bus.err}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/delta_madd_param.md
DELTA_MADD_PARAM -- requirements
Module: delta_madd_param

Interface
REQ-001 The module SHALL declare parameter DEPTH, default 16, as the number of memory entries (power of two, >=4).
REQ-002 The module SHALL declare parameter DATA_W, default 4, as the unsigned load data width.
REQ-003 The module SHALL declare parameter MEM_W, default 10, as the signed memory entry width.
REQ-004 The module SHALL declare parameter ACC_W, default 12, as the signed delta/count/total/result width.
REQ-005 The module SHALL derive IDX_W = clog2(DEPTH) internally, not as a settable parameter.
REQ-006 Port clk SHALL be an input of width 1: the single clock; all logic is rising-edge.
REQ-007 Port rst SHALL be an input of width 1: reset, synchronous and active-high.
REQ-008 Port op SHALL be an input of width 2: 00 MIN, 01 MAX, 10 MADD, 11 CLEAR.
REQ-009 Port load SHALL be an input of width 1: one-cycle memory write strobe.
REQ-010 Port index SHALL be an input of width IDX_W: the write address.
REQ-011 Port data SHALL be an input of width DATA_W: the unsigned MADD weight.
REQ-012 Port start SHALL be an input of width 1: begins a scan using op.
REQ-013 Port busy SHALL be an output of width 1: high while scanning.
REQ-014 Port done SHALL be an output of width 1: one-cycle pulse at scan end.
REQ-015 Port found SHALL be an output of width 1: MIN/MAX hit flag.
REQ-016 Port result SHALL be an output of width ACC_W: scan result.
REQ-017 Port err SHALL be an output of width 1: sticky protocol-error flag.
REQ-018 Port ovf SHALL be an output of width 1: accumulator overflow in the last MADD scan.

Function
REQ-019 The FSM SHALL have states IDLE, SCAN and DONE; transitions SHALL be IDLE->SCAN on start, SCAN->DONE on scan end, and DONE->IDLE unconditionally; busy=1 only in SCAN, and done=1 only in DONE.
REQ-020 A load in IDLE with op 00/01 SHALL write mem[index] <= 1.
REQ-021 A load in IDLE with op 10 SHALL perform mem[index] += data and mem[index-1] -= data, zero-extended and wrapping mod 2^MEM_W; at index 0 only mem[0] += data is performed, with no wrap to DEPTH-1.
REQ-022 A load in IDLE with op 11 SHALL zero all entries in that cycle.
REQ-023 A start in IDLE SHALL latch op and clear found, ovf, delta, count and total.
REQ-024 A MIN scan SHALL visit i = 0, 1, … one entry per cycle and end at the first mem[i] != 0 with result = i zero-extended and found = 1.
REQ-025 A MAX scan SHALL be identical to MIN except that it visits i = DEPTH-1 downward.
REQ-026 If a MIN/MAX scan finds no hit, it SHALL end after DEPTH cycles with result = 0 and found = 0.
REQ-027 A MADD scan SHALL visit i = DEPTH-1 down to 0, one entry per cycle, computing delta += mem[i] (sign-extended), then count += new delta, then total += new count.
REQ-028 A MADD scan SHALL end after exactly DEPTH cycles with result = total, which equals the sum over loads of data*(index+1) absent overflow.
REQ-029 A start with latched op 11 SHALL be a no-op scan: one SCAN cycle, with result and found unchanged.
REQ-030 result and found SHALL update on entry to DONE and hold until the next start.
REQ-031 A load or start while busy SHALL be ignored and SHALL set err.
REQ-032 On simultaneous load and start in IDLE, the load SHALL execute, the start SHALL be ignored, and err SHALL be set.
REQ-033 err SHALL clear only on rst.

Reset
REQ-034 While rst=1 at a clock edge, the state SHALL go to IDLE, all memory entries, delta, count, total and result SHALL be set to 0, and busy, done, found, err and ovf SHALL be set to 0.
REQ-035 Reset asserted mid-scan SHALL abort the scan without asserting done.

Configuration
REQ-036 With macro DELTA_MADD_SAT_EN defined, the count and total additions SHALL saturate to the signed ACC_W limits, and ovf SHALL be set on any clamp.
REQ-037 Without DELTA_MADD_SAT_EN, the additions SHALL wrap mod 2^ACC_W, and ovf SHALL be set on any signed overflow of count or total.

Verification
REQ-038 The bench SHALL cover: rst; MADD load idx5 data3; start op=10 -> busy for 16 cycles, done pulse, result=18, ovf=0.
REQ-039 The bench SHALL cover: rst; MADD loads (idx0,d7),(idx15,d1) -> result=7+16=23.
REQ-040 The bench SHALL cover: rst; load op=00 idx9; start MIN -> found=1, result=9, done 11 cycles after start; start MAX -> result=9.
REQ-041 The bench SHALL cover: rst; start MIN on an empty memory -> done after 16 scan cycles, found=0, result=0.
REQ-042 The bench SHALL cover: 15 MADD loads idx15 d15, ACC_W=12; start MADD -> with SAT_EN result=2047 and ovf=1; without SAT_EN ovf=1.
REQ-043 The bench SHALL cover: load during SCAN -> memory unchanged and err=1; rst mid-scan -> busy=0, no done pulse, all outputs 0.
